// File: rtl/bless_router_p.sv
// Bufferless deflection mesh router: stage 1 registers flits with hops+1 and a desired-port mask;
// stage 2 does oldest-first allocation (rotating tie-break) with ejection, deflection and injection.
module bless_router_p #(
  parameter int unsigned LINKWIDTH   = 128,
  parameter int unsigned XBITS       = 2,
  parameter int unsigned YBITS       = 2,
  parameter int unsigned HOPBITS     = 8,
  parameter int unsigned EJECT_WIDTH = 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [XBITS+YBITS-1:0]                  ID,
  input  logic [4*LINKWIDTH-1:0]                  in_data,
  input  logic [4*2*(XBITS+YBITS)-1:0]            in_srcdst,
  input  logic [3:0]                              in_active,
  input  logic [4*HOPBITS-1:0]                    in_hops,
  output logic [4*LINKWIDTH-1:0]                  out_data,
  output logic [4*2*(XBITS+YBITS)-1:0]            out_srcdst,
  output logic [3:0]                              out_active,
  output logic [4*HOPBITS-1:0]                    out_hops,
  input  logic [LINKWIDTH-1:0]                    in_data_inj,
  input  logic [2*(XBITS+YBITS)-1:0]              in_srcdst_inj,
  input  logic                                    in_active_inj,
  output logic                                    in_accepted_inj,
  output logic [EJECT_WIDTH*LINKWIDTH-1:0]        out_data_ej,
  output logic [EJECT_WIDTH*2*(XBITS+YBITS)-1:0]  out_srcdst_ej,
  output logic [EJECT_WIDTH-1:0]                  out_active_ej,
  output logic [15:0]                             stat_deflect
);

  localparam int unsigned ADDRBITS  = XBITS + YBITS;
  localparam int unsigned ADDRBITS2 = 2 * ADDRBITS;
  // Productive-port search order, LSB first: E, W, S, N (X before Y)
  localparam logic [7:0]  XY_ORDER  = {2'd0, 2'd2, 2'd3, 2'd1};

  // Mask bits: 0=N 1=E 2=S 3=W 4=eject
  function automatic logic [4:0] f_desire(input logic [ADDRBITS-1:0] dst,
                                          input logic [ADDRBITS-1:0] id);
    logic [4:0] d;
    d = '0;
    if (dst == id) begin
      d[4] = 1'b1;
    end else begin
      if (dst[XBITS-1:0] > id[XBITS-1:0])               d[1] = 1'b1;
      if (dst[XBITS-1:0] < id[XBITS-1:0])               d[3] = 1'b1;
      if (dst[ADDRBITS-1:XBITS] > id[ADDRBITS-1:XBITS]) d[2] = 1'b1;
      if (dst[ADDRBITS-1:XBITS] < id[ADDRBITS-1:XBITS]) d[0] = 1'b1;
    end
    return d;
  endfunction

  logic [LINKWIDTH-1:0] w_in_data [4];
  logic [ADDRBITS2-1:0] w_in_sd   [4];
  logic [HOPBITS-1:0]   w_in_hops [4];

  logic [3:0]           r_v;
  logic [LINKWIDTH-1:0] r_data [4];
  logic [ADDRBITS2-1:0] r_sd   [4];
  logic [HOPBITS-1:0]   r_hops [4];
  logic [4:0]           r_des  [4];
  logic [1:0]           r_rr;

  logic [3:0]           r_act;
  logic [LINKWIDTH-1:0] r_odata [4];
  logic [ADDRBITS2-1:0] r_osd   [4];
  logic [HOPBITS-1:0]   r_ohops [4];
  logic [EJECT_WIDTH-1:0] r_ej_act;
  logic [LINKWIDTH-1:0] r_ej_data [EJECT_WIDTH];
  logic [ADDRBITS2-1:0] r_ej_sd   [EJECT_WIDTH];
  logic [15:0]          r_stat;

  for (genvar g_p = 0; g_p < 4; g_p++) begin : g_port
    assign w_in_data[g_p] = in_data[g_p*LINKWIDTH +: LINKWIDTH];
    assign w_in_sd[g_p]   = in_srcdst[g_p*ADDRBITS2 +: ADDRBITS2];
    assign w_in_hops[g_p] = in_hops[g_p*HOPBITS +: HOPBITS];
    assign out_data[g_p*LINKWIDTH +: LINKWIDTH]   = r_odata[g_p];
    assign out_srcdst[g_p*ADDRBITS2 +: ADDRBITS2] = r_osd[g_p];
    assign out_hops[g_p*HOPBITS +: HOPBITS]       = r_ohops[g_p];
  end

  for (genvar g_s = 0; g_s < EJECT_WIDTH; g_s++) begin : g_ej
    assign out_data_ej[g_s*LINKWIDTH +: LINKWIDTH]   = r_ej_data[g_s];
    assign out_srcdst_ej[g_s*ADDRBITS2 +: ADDRBITS2] = r_ej_sd[g_s];
  end

  assign out_active    = r_act;
  assign out_active_ej = r_ej_act;
  assign stat_deflect  = r_stat;

  // Stage 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_v <= '0;
    else       r_v <= in_active;
  end

  always_ff @(posedge clock) begin
    for (int p = 0; p < 4; p++) begin
      r_data[p] <= w_in_data[p];
      r_sd[p]   <= w_in_sd[p];
      r_hops[p] <= (&w_in_hops[p]) ? w_in_hops[p] : w_in_hops[p] + HOPBITS'(1);
      r_des[p]  <= f_desire(w_in_sd[p][ADDRBITS-1:0], ID);
    end
  end

  // Priority rank: 0 is served first
  logic [1:0] w_dist [4];
  logic [1:0] w_rank [4];

  always_comb begin
    for (int p = 0; p < 4; p++) w_dist[p] = 2'(p) - r_rr;
    for (int p = 0; p < 4; p++) begin
      w_rank[p] = '0;
      for (int q = 0; q < 4; q++) begin
        if (q != p && r_v[q] && (!r_v[p] || r_hops[q] > r_hops[p] ||
            (r_hops[q] == r_hops[p] && w_dist[q] < w_dist[p]))) begin
          w_rank[p] = w_rank[p] + 2'd1;
        end
      end
    end
  end

  // Stage 2 allocation
  logic [3:0]             w_free;
  logic [EJECT_WIDTH-1:0] w_ejfree;
  logic [2:0]             w_ndefl;
  logic [1:0]             w_sel;
  logic                   w_got, w_ej, w_acc;
  logic [4:0]             w_inj_des;
  logic [3:0]             w_nx_act;
  logic [LINKWIDTH-1:0]   w_nx_data [4];
  logic [ADDRBITS2-1:0]   w_nx_sd   [4];
  logic [HOPBITS-1:0]     w_nx_hops [4];
  logic [EJECT_WIDTH-1:0] w_nx_ej_act;
  logic [LINKWIDTH-1:0]   w_nx_ej_data [EJECT_WIDTH];
  logic [ADDRBITS2-1:0]   w_nx_ej_sd   [EJECT_WIDTH];
  logic [16:0]            w_stat_sum;

  always_comb begin
    w_free      = '1;
    w_ejfree    = '1;
    w_ndefl     = '0;
    w_sel       = '0;
    w_got       = 1'b0;
    w_ej        = 1'b0;
    w_acc       = 1'b0;
    w_nx_act    = '0;
    w_nx_ej_act = '0;
    w_inj_des   = f_desire(in_srcdst_inj[ADDRBITS-1:0], ID);
    for (int o = 0; o < 4; o++) begin
      w_nx_data[o] = '0;
      w_nx_sd[o]   = '0;
      w_nx_hops[o] = '0;
    end
    for (int s = 0; s < EJECT_WIDTH; s++) begin
      w_nx_ej_data[s] = '0;
      w_nx_ej_sd[s]   = '0;
    end
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        if (r_v[p] && w_rank[p] == 2'(k)) begin
          w_ej  = 1'b0;
          w_got = 1'b0;
          w_sel = '0;
          if (r_des[p][4]) begin
            for (int s = 0; s < EJECT_WIDTH; s++) begin
              if (!w_ej && w_ejfree[s]) begin
                w_ej            = 1'b1;
                w_ejfree[s]     = 1'b0;
                w_nx_ej_act[s]  = 1'b1;
                w_nx_ej_data[s] = r_data[p];
                w_nx_ej_sd[s]   = r_sd[p];
              end
            end
          end
          if (!w_ej) begin
            for (int i = 0; i < 4; i++) begin
              if (!w_got && r_des[p][XY_ORDER[2*i +: 2]] && w_free[XY_ORDER[2*i +: 2]]) begin
                w_got = 1'b1;
                w_sel = XY_ORDER[2*i +: 2];
              end
            end
            if (!w_got) begin
              for (int o = 0; o < 4; o++) begin
                if (!w_got && w_free[o]) begin
                  w_got = 1'b1;
                  w_sel = 2'(o);
                end
              end
              if (w_got) w_ndefl = w_ndefl + 3'd1;
            end
            if (w_got) begin
              w_free[w_sel]    = 1'b0;
              w_nx_act[w_sel]  = 1'b1;
              w_nx_data[w_sel] = r_data[p];
              w_nx_sd[w_sel]   = r_sd[p];
              w_nx_hops[w_sel] = r_hops[p];
            end
          end
        end
      end
    end
    // Injection takes whatever is left; a local-destination flit may only eject
    w_ej  = 1'b0;
    w_got = 1'b0;
    w_sel = '0;
    if (in_active_inj) begin
      if (w_inj_des[4]) begin
        for (int s = 0; s < EJECT_WIDTH; s++) begin
          if (!w_ej && w_ejfree[s]) begin
            w_ej            = 1'b1;
            w_ejfree[s]     = 1'b0;
            w_nx_ej_act[s]  = 1'b1;
            w_nx_ej_data[s] = in_data_inj;
            w_nx_ej_sd[s]   = in_srcdst_inj;
          end
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (!w_got && w_inj_des[XY_ORDER[2*i +: 2]] && w_free[XY_ORDER[2*i +: 2]]) begin
            w_got = 1'b1;
            w_sel = XY_ORDER[2*i +: 2];
          end
        end
        for (int o = 0; o < 4; o++) begin
          if (!w_got && w_free[o]) begin
            w_got = 1'b1;
            w_sel = 2'(o);
          end
        end
        if (w_got) begin
          w_free[w_sel]    = 1'b0;
          w_nx_act[w_sel]  = 1'b1;
          w_nx_data[w_sel] = in_data_inj;
          w_nx_sd[w_sel]   = in_srcdst_inj;
          w_nx_hops[w_sel] = '0;
        end
      end
    end
    w_acc      = w_ej | w_got;
    w_stat_sum = {1'b0, r_stat} + {14'd0, w_ndefl};
  end

  assign in_accepted_inj = w_acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr     <= '0;
      r_act    <= '0;
      r_ej_act <= '0;
      r_stat   <= '0;
      for (int o = 0; o < 4; o++) begin
        r_odata[o] <= '0;
        r_osd[o]   <= '0;
        r_ohops[o] <= '0;
      end
      for (int s = 0; s < EJECT_WIDTH; s++) begin
        r_ej_data[s] <= '0;
        r_ej_sd[s]   <= '0;
      end
    end else begin
      r_rr     <= r_rr + 2'd1;
      r_act    <= w_nx_act;
      r_ej_act <= w_nx_ej_act;
      r_stat   <= w_stat_sum[16] ? 16'hFFFF : w_stat_sum[15:0];
      for (int o = 0; o < 4; o++) begin
        r_odata[o] <= w_nx_data[o];
        r_osd[o]   <= w_nx_sd[o];
        r_ohops[o] <= w_nx_hops[o];
      end
      for (int s = 0; s < EJECT_WIDTH; s++) begin
        r_ej_data[s] <= w_nx_ej_data[s];
        r_ej_sd[s]   <= w_nx_ej_sd[s];
      end
    end
  end

endmodule

// File: tb/tb_bless_router_p.sv
// Directed vector bench for bless_router_p at ID={y1,x1}: one single-eject and one dual-eject
// instance share all inputs.
module tb_bless_router_p;
  localparam int LW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    id    = 4'd5;
  logic [4*LW-1:0] in_data;
  logic [31:0]   in_srcdst;
  logic [3:0]    in_active;
  logic [31:0]   in_hops;
  logic [LW-1:0] in_data_inj;
  logic [7:0]    in_srcdst_inj;
  logic          in_active_inj;

  logic [4*LW-1:0] out_data, u2_out_data;
  logic [31:0]   out_srcdst, out_hops, u2_out_srcdst, u2_out_hops;
  logic [3:0]    out_active, u2_out_active;
  logic          acc, u2_acc;
  logic [LW-1:0] ej_data;
  logic [7:0]    ej_sd;
  logic [0:0]    ej_act;
  logic [2*LW-1:0] u2_ej_data;
  logic [15:0]   u2_ej_sd;
  logic [1:0]    u2_ej_act;
  logic [15:0]   stat, u2_stat;

  bless_router_p #(.LINKWIDTH(LW), .XBITS(2), .YBITS(2), .HOPBITS(8), .EJECT_WIDTH(1)) u_dut (
    .clock(clock), .reset(reset), .ID(id),
    .in_data(in_data), .in_srcdst(in_srcdst), .in_active(in_active), .in_hops(in_hops),
    .out_data(out_data), .out_srcdst(out_srcdst), .out_active(out_active), .out_hops(out_hops),
    .in_data_inj(in_data_inj), .in_srcdst_inj(in_srcdst_inj), .in_active_inj(in_active_inj),
    .in_accepted_inj(acc), .out_data_ej(ej_data), .out_srcdst_ej(ej_sd),
    .out_active_ej(ej_act), .stat_deflect(stat)
  );

  bless_router_p #(.LINKWIDTH(LW), .XBITS(2), .YBITS(2), .HOPBITS(8), .EJECT_WIDTH(2)) u_dut2 (
    .clock(clock), .reset(reset), .ID(id),
    .in_data(in_data), .in_srcdst(in_srcdst), .in_active(in_active), .in_hops(in_hops),
    .out_data(u2_out_data), .out_srcdst(u2_out_srcdst), .out_active(u2_out_active),
    .out_hops(u2_out_hops),
    .in_data_inj(in_data_inj), .in_srcdst_inj(in_srcdst_inj), .in_active_inj(in_active_inj),
    .in_accepted_inj(u2_acc), .out_data_ej(u2_ej_data), .out_srcdst_ej(u2_ej_sd),
    .out_active_ej(u2_ej_act), .stat_deflect(u2_stat)
  );

  always #5 clock = ~clock;

  // Tie-break pointer as the router's behaviour defines it: cleared by reset, +1 per clock
  logic [1:0] tb_rr;
  always @(posedge clock or posedge reset) begin
    if (reset) tb_rr <= 2'd0;
    else       tb_rr <= tb_rr + 2'd1;
  end

  int total = 0;
  int bad   = 0;
  int exp_stat = 0;

  typedef struct {
    logic [3:0]       act;
    logic [3:0][3:0]  dst;
    logic [3:0][7:0]  hops;
    int               rr;      // required tie-break pointer during allocation, 4 = any
    logic             inj;
    logic [3:0]       inj_dst;
    logic [3:0][2:0]  e_src;   // source per output: 0..3 input, 4 injection, 7 idle
    int               e_ej;    // ejected source, -1 none
    logic             e_acc;
    int               e_defl;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  task automatic chk(input string nm, input int idx, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (case %0d): got %h, expected %h", nm, idx, got, exp);
    end
  endtask

  function automatic logic [15:0] f_data(input int p);
    return 16'h10A5 + 16'(p) * 16'h1000;
  endfunction

  function automatic logic [32:0] f_net(input int p, input logic [3:0] dst, input logic [7:0] h);
    logic [7:0] hn;
    hn = (h == 8'hFF) ? h : h + 8'd1;
    return {1'b1, f_data(p), 4'(p), dst, hn};
  endfunction

  function automatic logic [32:0] f_inj(input logic [3:0] dst);
    return {1'b1, 16'hBEEF, 4'hF, dst, 8'h00};
  endfunction

  function automatic logic [32:0] f_port(input int o);
    return {out_active[o], out_data[o*LW +: LW], out_srcdst[o*8 +: 8], out_hops[o*8 +: 8]};
  endfunction

  task automatic clr_net();
    in_active = '0; in_data = '0; in_srcdst = '0; in_hops = '0;
  endtask

  task automatic clr_inj();
    in_active_inj = 1'b0; in_data_inj = '0; in_srcdst_inj = '0;
  endtask

  task automatic drive_flit(input int p, input int dst, input int h);
    in_active[p]        = 1'b1;
    in_data[p*LW +: LW] = f_data(p);
    in_srcdst[p*8 +: 8] = {4'(p), 4'(dst)};
    in_hops[p*8 +: 8]   = 8'(h);
  endtask

  task automatic drive_inj(input int dst);
    in_active_inj = 1'b1; in_data_inj = 16'hBEEF; in_srcdst_inj = {4'hF, 4'(dst)};
  endtask

  task automatic vnew(input int i, input int rr);
    vt[i].act = '0; vt[i].dst = '0; vt[i].hops = '0; vt[i].rr = rr;
    vt[i].inj = 1'b0; vt[i].inj_dst = '0; vt[i].e_src = {4{3'd7}};
    vt[i].e_ej = -1; vt[i].e_acc = 1'b0; vt[i].e_defl = 0;
  endtask

  task automatic vin(input int i, input int p, input int dst, input int h);
    vt[i].act[p] = 1'b1; vt[i].dst[p] = 4'(dst); vt[i].hops[p] = 8'(h);
  endtask

  task automatic vout(input int i, input int o, input int src);
    vt[i].e_src[o] = 3'(src);
  endtask

  task automatic vinj(input int i, input int dst, input logic a);
    vt[i].inj = 1'b1; vt[i].inj_dst = 4'(dst); vt[i].e_acc = a;
  endtask

  task automatic apply(input int i);
    int src;
    logic [32:0] pe;
    logic [24:0] ee;
    for (int w = 0; w < 4; w++)
      if (vt[i].rr < 4 && (tb_rr + 2'd1) != 2'(vt[i].rr)) @(negedge clock);
    clr_net();
    for (int p = 0; p < 4; p++)
      if (vt[i].act[p]) drive_flit(p, int'(vt[i].dst[p]), int'(vt[i].hops[p]));
    @(posedge clock);
    @(negedge clock);
    clr_net();
    if (vt[i].inj) drive_inj(int'(vt[i].inj_dst));
    #1;
    chk("accept", i, 64'(acc), 64'(vt[i].e_acc));
    @(posedge clock);
    @(negedge clock);
    clr_inj();
    exp_stat += vt[i].e_defl;
    for (int o = 0; o < 4; o++) begin
      src = int'(vt[i].e_src[o]);
      if (src == 7)      pe = '0;
      else if (src == 4) pe = f_inj(vt[i].inj_dst);
      else               pe = f_net(src, vt[i].dst[src], vt[i].hops[src]);
      chk($sformatf("port%0d", o), i, 64'(f_port(o)), 64'(pe));
    end
    if (vt[i].e_ej < 0)       ee = '0;
    else if (vt[i].e_ej == 4) ee = {1'b1, 16'hBEEF, 4'hF, vt[i].inj_dst};
    else ee = {1'b1, f_data(vt[i].e_ej), 4'(vt[i].e_ej), vt[i].dst[vt[i].e_ej]};
    chk("eject", i, 64'({ej_act, ej_data, ej_sd}), 64'(ee));
    chk("stat", i, 64'(stat), 64'(exp_stat));
  endtask

  initial begin
    clr_net();
    clr_inj();

    // Addresses {y,x}: 7=E-only 4=W-only 13=S-only 1=N-only 10=E+S 5=local
    vnew(0, 4);  vin(0, 3, 7, 5); vout(0, 1, 3);
    vnew(1, 4);  vin(1, 0, 7, 9); vin(1, 2, 7, 3); vout(1, 1, 0); vout(1, 0, 2);
    vt[1].e_defl = 1;
    vnew(2, 2);  vin(2, 0, 7, 4); vin(2, 2, 7, 4); vout(2, 1, 2); vout(2, 0, 0);
    vt[2].e_defl = 1;
    vnew(3, 4);  vin(3, 2, 10, 9); vin(3, 0, 10, 3); vout(3, 1, 2); vout(3, 2, 0);
    vnew(4, 4);  vin(4, 0, 5, 7); vin(4, 1, 5, 2); vout(4, 0, 1);
    vt[4].e_ej = 0; vt[4].e_defl = 1;
    vnew(5, 4);  vin(5, 3, 7, 255); vin(5, 1, 4, 254); vout(5, 1, 3); vout(5, 3, 1);
    vnew(6, 4);  vin(6, 0, 13, 1); vin(6, 1, 4, 1); vin(6, 2, 1, 1); vinj(6, 7, 1'b1);
    vout(6, 2, 0); vout(6, 3, 1); vout(6, 0, 2); vout(6, 1, 4);
    vnew(7, 4);  vinj(7, 5, 1'b1); vt[7].e_ej = 4;
    vnew(8, 4);  vinj(8, 13, 1'b1); vout(8, 2, 4);
    vnew(9, 4);  vin(9, 0, 5, 1); vin(9, 1, 4, 1); vin(9, 2, 1, 1); vin(9, 3, 7, 1);
    vinj(9, 7, 1'b1); vt[9].e_ej = 0; vout(9, 3, 1); vout(9, 0, 2); vout(9, 1, 3); vout(9, 2, 4);
    vnew(10, 4); vin(10, 0, 5, 1); vin(10, 1, 4, 1); vin(10, 2, 1, 1); vin(10, 3, 7, 1);
    vinj(10, 5, 1'b0); vt[10].e_ej = 0; vout(10, 3, 1); vout(10, 0, 2); vout(10, 1, 3);
    vnew(11, 1); vin(11, 1, 1, 3); vin(11, 3, 1, 3); vout(11, 0, 1); vout(11, 1, 3);
    vt[11].e_defl = 1;
    vnew(12, 3); vin(12, 1, 1, 3); vin(12, 3, 1, 3); vout(12, 0, 3); vout(12, 1, 1);
    vt[12].e_defl = 1;

    // Power-on reset, idle network
    repeat (3) @(negedge clock);
    chk("rst_active", 0, 64'(out_active), 64'(0));
    reset = 1'b0;
    repeat (2) begin @(posedge clock); @(negedge clock); end
    chk("idle_active", 0, 64'(out_active), 64'(0));
    chk("idle_ej", 0, 64'(ej_act), 64'(0));
    chk("idle_stat", 0, 64'(stat), 64'(0));
    chk("idle_accept", 0, 64'(acc), 64'(0));

    for (int i = 0; i < NV; i++) apply(i);

    // Injection held against a full network, accepted once a port frees up
    drive_flit(0, 13, 1); drive_flit(1, 4, 1); drive_flit(2, 1, 1); drive_flit(3, 7, 1);
    drive_inj(7);
    @(posedge clock); @(negedge clock);
    clr_net(); drive_flit(0, 13, 1); drive_flit(1, 4, 1); drive_flit(2, 1, 1);
    #1 chk("hold_noacc", 100, 64'(acc), 64'(0));
    @(posedge clock); @(negedge clock);
    clr_net();
    #1 chk("hold_acc", 101, 64'(acc), 64'(1));
    chk("hold_full", 101, 64'(out_active), 64'(4'hF));
    @(posedge clock); @(negedge clock);
    clr_inj();
    chk("hold_inj_e", 102, 64'(f_port(1)), 64'(f_inj(4'd7)));
    chk("hold_s", 102, 64'(f_port(2)), 64'(f_net(0, 4'd13, 8'd1)));
    chk("hold_n", 102, 64'(f_port(0)), 64'(f_net(2, 4'd1, 8'd1)));

    // Dual ejection: both local flits eject, older one in slot 0
    drive_flit(0, 5, 7); drive_flit(1, 5, 2);
    @(posedge clock); @(negedge clock);
    clr_net();
    @(posedge clock); @(negedge clock);
    exp_stat += 1;
    chk("ej2_act", 200, 64'(u2_ej_act), 64'(2'b11));
    chk("ej2_slot0", 200, 64'({u2_ej_data[15:0], u2_ej_sd[7:0]}), 64'({16'h10A5, 8'h05}));
    chk("ej2_slot1", 200, 64'({u2_ej_data[31:16], u2_ej_sd[15:8]}), 64'({16'h20A5, 8'h15}));
    chk("ej2_net", 200, 64'(u2_out_active), 64'(0));
    chk("ej1_stat", 200, 64'(stat), 64'(exp_stat));

    // Reset with flits both at the outputs and in stage 1
    drive_flit(0, 13, 1); drive_flit(1, 4, 1); drive_flit(2, 1, 1); drive_flit(3, 7, 1);
    @(posedge clock); @(posedge clock);
    #2 chk("pre_rst", 300, 64'(out_active), 64'(4'hF));
    reset = 1'b1;
    #1 chk("rst_now_act", 300, 64'(out_active), 64'(0));
    chk("rst_now_stat", 300, 64'(stat), 64'(0));
    exp_stat = 0;
    @(negedge clock);
    clr_net();
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("post_rst1", 301, 64'({out_active, ej_act}), 64'(0));
    @(posedge clock); @(negedge clock);
    chk("post_rst2", 302, 64'({out_active, ej_act}), 64'(0));
    chk("post_rst_stat", 302, 64'(stat), 64'(exp_stat));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
